// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI lines, status bits and backdoor port of the flash responder
interface spi_flash_responder_if #(
    parameter int ADDR_BITS = 12
);
    logic                 i_SPI_CLK;
    logic                 i_SPI_CS;
    logic                 i_SPI_MOSI;
    logic                 o_WIP;
    logic                 o_WEL;
    logic [ADDR_BITS-1:0] i_dbg_addr;
    logic [7:0]           o_dbg_data;

    modport master (
        output i_SPI_CLK, i_SPI_CS, i_SPI_MOSI, i_dbg_addr,
        input  o_WIP, o_WEL, o_dbg_data
    );

    modport slave (
        input  i_SPI_CLK, i_SPI_CS, i_SPI_MOSI, i_dbg_addr,
        output o_WIP, o_WEL, o_dbg_data
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: oversampled SPI mode 0 flash target (WREN/WRDI/RDSR/READ/PP) over an on-chip byte array
module spi_flash_responder #(
    parameter int ADDR_BITS    = 12,
    parameter int PAGE_BITS    = 8,
    parameter int WRITE_CYCLES = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_flash_responder_if.slave   bus,
    output logic                   o_SPI_MISO
);
    localparam int TW = $clog2(WRITE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, PROG, STATUS, IGNORE} state_t;

    // Bytes are stored complemented so the all-zero power-up contents read back as erased 0xFF.
    logic [7:0]           mem [2**ADDR_BITS];

    state_t               state_q;
    logic [2:0]           sclk_q;
    logic [2:0]           cs_q;
    logic [1:0]           mosi_q;
    logic [2:0]           bit_q;
    logic [1:0]           nb_q;
    logic [6:0]           shift_q;
    logic [7:0]           out_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 rd_q;
    logic                 any_q;
    logic                 miso_q;
    logic                 miso_en_q;
    logic                 wip_q;
    logic                 wel_q;
    logic [TW-1:0]        timer_q;
    logic [7:0]           dbg_q;

    logic                 rise, fall, cs_s, cs_rise, byte_done, we;
    logic [7:0]           rx_d, status_d, rd_data_d;
    logic [ADDR_BITS-1:0] addr_next_d, addr_inc_d, page_inc_d;

    assign rise        = sclk_q[1] & ~sclk_q[2];
    assign fall        = ~sclk_q[1] & sclk_q[2];
    assign cs_s        = cs_q[1];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign rx_d        = {shift_q, mosi_q[1]};
    assign byte_done   = rise & ~cs_s & (bit_q == 3'd7);
    assign we          = byte_done & (state_q == PROG);
    assign status_d    = {6'b0, wel_q, wip_q};
    assign addr_next_d = ADDR_BITS'({addr_q, rx_d});
    assign addr_inc_d  = addr_q + ADDR_BITS'(1);
    assign page_inc_d  = {addr_q[ADDR_BITS-1:PAGE_BITS], addr_q[PAGE_BITS-1:0] + PAGE_BITS'(1)};
    assign rd_data_d   = ~mem[(state_q == ADDR) ? addr_next_d : addr_inc_d];

    assign bus.o_WIP      = wip_q;
    assign bus.o_WEL      = wel_q;
    assign bus.o_dbg_data = dbg_q;
    assign o_SPI_MISO     = miso_en_q ? miso_q : 1'bz;

    // Array write port; deliberately outside reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr_q] <= ~rx_d;
    end

    // Synchronizers, command FSM, shifters, status latches and write timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sclk_q    <= '0;
            cs_q      <= '1;
            mosi_q    <= '0;
            bit_q     <= '0;
            nb_q      <= '0;
            shift_q   <= '0;
            out_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            any_q     <= 1'b0;
            miso_q    <= 1'b0;
            miso_en_q <= 1'b0;
            wip_q     <= 1'b0;
            wel_q     <= 1'b0;
            timer_q   <= '0;
            dbg_q     <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.i_SPI_CLK};
            cs_q   <= {cs_q[1:0], bus.i_SPI_CS};
            mosi_q <= {mosi_q[0], bus.i_SPI_MOSI};
            dbg_q  <= ~mem[bus.i_dbg_addr];
            if (wip_q) begin
                timer_q <= timer_q - TW'(1);
                if (timer_q == TW'(1)) wip_q <= 1'b0;
            end
            if (cs_s) begin
                state_q   <= IDLE;
                bit_q     <= '0;
                miso_en_q <= 1'b0;
                if (cs_rise && state_q == PROG && any_q) begin
                    wip_q   <= 1'b1;
                    wel_q   <= 1'b0;
                    timer_q <= TW'(WRITE_CYCLES);
                end
            end else if (state_q == IDLE) begin
                state_q <= CMD;
                bit_q   <= '0;
                nb_q    <= '0;
                any_q   <= 1'b0;
            end else begin
                if (fall && (state_q == READ || state_q == STATUS)) begin
                    miso_q    <= out_q[7];
                    out_q     <= {out_q[6:0], 1'b0};
                    miso_en_q <= 1'b1;
                end
                if (rise) begin
                    shift_q <= rx_d[6:0];
                    bit_q   <= bit_q + 3'd1;
                end
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            state_q <= IGNORE;
                            case (rx_d)
                                8'h06: if (!wip_q) wel_q <= 1'b1;
                                8'h04: if (!wip_q) wel_q <= 1'b0;
                                8'h05: begin
                                    state_q <= STATUS;
                                    out_q   <= status_d;
                                end
                                8'h03: begin
                                    state_q <= wip_q ? IGNORE : ADDR;
                                    rd_q    <= 1'b1;
                                end
                                8'h02: begin
                                    state_q <= (!wip_q && wel_q) ? ADDR : IGNORE;
                                    rd_q    <= 1'b0;
                                end
                                default: ;
                            endcase
                        end
                        ADDR: begin
                            addr_q <= addr_next_d;
                            nb_q   <= nb_q + 2'd1;
                            if (nb_q == 2'd2) begin
                                state_q <= rd_q ? READ : PROG;
                                if (rd_q) out_q <= rd_data_d;
                            end
                        end
                        READ: begin
                            addr_q <= addr_inc_d;
                            out_q  <= rd_data_d;
                        end
                        STATUS: out_q <= status_d;
                        PROG: begin
                            addr_q <= page_inc_d;
                            any_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
